// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation and vend/change sequencing for the
// chocolate vending machine. Coin buttons and cancel are active-low and
// edge-detected after one register stage; credit is held in 5-cent units.
//
// Optional build macro SALES_AUDIT_EN adds sales_cnt (wrapping count of
// acknowledged vends) and refund_cnt (saturating count of refund entries).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no credit, waiting for the first coin
// COLLECT | credit below price, accepting coins or cancel
// VEND    | disp_req held, waiting for disp_ack or timeout
// CHANGE  | paying out the remainder after a vend, one coin per gap
// REFUND  | paying out the full credit after cancel or vend timeout
module vend_sequencer #(
  parameter int unsigned PRICE_UNITS = 9,
  parameter int unsigned MAX_UNITS   = 15,
  parameter int unsigned CHG_GAP     = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c5,
  input  logic       c10,
  input  logic       c20,
  input  logic       cancel_n,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic       chg5_pulse,
  output logic       coin_rej,
  output logic       vend_err,
  output logic       busy,
  output logic [3:0] led
`ifdef SALES_AUDIT_EN
  ,
  output logic [15:0] sales_cnt,
  output logic [7:0]  refund_cnt
`endif
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(CHG_GAP + 1);

  // Down-counter reloads: terminal count at zero gives exactly N cycles.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CHG_GAP - 1);
  localparam logic [4:0]       PRICE5   = 5'(PRICE_UNITS);
  localparam logic [4:0]       MAX5     = 5'(MAX_UNITS);
  localparam logic [3:0]       PRICE4   = 4'(PRICE_UNITS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       credit, credit_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic [GAP_W-1:0] gap, gap_nx;
  logic             chg_nx, rej_nx, err_nx;

  logic c5_q, c10_q, c20_q, can_q;
  logic c5_qq, c10_qq, c20_qq, can_qq;
  logic ev5, ev10, ev20, ev_can, any_coin, low_rej;
  logic [2:0] coin_val;
  logic [4:0] sum5;

  // Register the buttons once, then keep the previous value for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c5_q   <= 1'b1;
      c10_q  <= 1'b1;
      c20_q  <= 1'b1;
      can_q  <= 1'b1;
      c5_qq  <= 1'b1;
      c10_qq <= 1'b1;
      c20_qq <= 1'b1;
      can_qq <= 1'b1;
    end else begin
      c5_q   <= c5;
      c10_q  <= c10;
      c20_q  <= c20;
      can_q  <= cancel_n;
      c5_qq  <= c5_q;
      c10_qq <= c10_q;
      c20_qq <= c20_q;
      can_qq <= can_q;
    end
  end

  assign ev5      = c5_qq  & ~c5_q;
  assign ev10     = c10_qq & ~c10_q;
  assign ev20     = c20_qq & ~c20_q;
  assign ev_can   = can_qq & ~can_q;
  assign any_coin = ev5 | ev10 | ev20;

  // Pick the highest-priority coin; any lower coin on the same edge is rejected.
  always_comb begin
    coin_val = 3'd0;
    low_rej  = 1'b0;
    if (ev5) begin
      coin_val = 3'd1;
      low_rej  = ev10 | ev20;
    end else if (ev10) begin
      coin_val = 3'd2;
      low_rej  = ev20;
    end else if (ev20) begin
      coin_val = 3'd4;
    end
  end

  assign sum5 = {1'b0, credit} + {2'b00, coin_val};

  // Next-state, credit and pulse decisions.
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    tmr_nx    = tmr;
    gap_nx    = gap;
    chg_nx    = 1'b0;
    rej_nx    = 1'b0;
    err_nx    = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (ev_can && (credit != 4'd0)) begin
          // Cancel wins over a coin arriving on the same edge.
          state_nx = S_REFUND;
          gap_nx   = GAP_LOAD;
          rej_nx   = any_coin;
        end else if (any_coin) begin
          rej_nx = low_rej;
          if (sum5 > MAX5) begin
            rej_nx = 1'b1;
          end else begin
            credit_nx = sum5[3:0];
            if (sum5 >= PRICE5) begin
              state_nx = S_VEND;
              tmr_nx   = TMR_LOAD;
            end else begin
              state_nx = S_COLLECT;
            end
          end
        end
      end
      S_VEND: begin
        rej_nx = any_coin;
        if (disp_ack) begin
          credit_nx = credit - PRICE4;
          if (credit_nx != 4'd0) begin
            state_nx = S_CHANGE;
            gap_nx   = GAP_LOAD;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (tmr == '0) begin
          err_nx   = 1'b1;
          state_nx = S_REFUND;
          gap_nx   = GAP_LOAD;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      S_CHANGE, S_REFUND: begin
        rej_nx = any_coin;
        if (credit == 4'd0) begin
          state_nx = S_IDLE;
        end else if (gap == '0) begin
          chg_nx    = 1'b1;
          credit_nx = credit - 4'd1;
          gap_nx    = GAP_LOAD;
          if (credit == 4'd1) state_nx = S_IDLE;
        end else begin
          gap_nx = gap - GAP_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, credit, timers and registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      credit     <= 4'd0;
      tmr        <= '0;
      gap        <= '0;
      chg5_pulse <= 1'b0;
      coin_rej   <= 1'b0;
      vend_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      credit     <= credit_nx;
      tmr        <= tmr_nx;
      gap        <= gap_nx;
      chg5_pulse <= chg_nx;
      coin_rej   <= rej_nx;
      vend_err   <= err_nx;
    end
  end

  // Decoded from the state register so reset drops disp_req without a clock.
  assign disp_req = (state == S_VEND);
  assign busy     = (state == S_VEND) || (state == S_CHANGE) || (state == S_REFUND);
  assign led      = ~credit;

`ifdef SALES_AUDIT_EN
  logic sale_ev, refund_ev;
  assign sale_ev   = (state == S_VEND) && disp_ack;
  assign refund_ev = (state_nx == S_REFUND) && (state != S_REFUND);

  // Audit counters: sales wrap, refunds saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sales_cnt  <= 16'd0;
      refund_cnt <= 8'd0;
    end else begin
      if (sale_ev) sales_cnt <= sales_cnt + 16'd1;
      if (refund_ev && (refund_cnt != 8'hFF)) refund_cnt <= refund_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a per-cycle vector table for the basic
// buy, then hand-written sequences for change spacing, refund, timeout,
// coin priority, mid-vend reset and credit overflow (second instance with a
// price of 15 so that a credit of 13 is reachable).
module tb_vend_sequencer;

  localparam int CHG_GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c5 = 1'b1, c10 = 1'b1, c20 = 1'b1, cancel_n = 1'b1, disp_ack = 1'b0;

  logic       disp_req, chg5_pulse, coin_rej, vend_err, busy;
  logic [3:0] led;
  logic       disp_req_h, chg5_pulse_h, coin_rej_h, vend_err_h, busy_h;
  logic [3:0] led_h;
`ifdef SALES_AUDIT_EN
  logic [15:0] sales_cnt, sales_cnt_h;
  logic [7:0]  refund_cnt, refund_cnt_h;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_sequencer #(.PRICE_UNITS(9), .MAX_UNITS(15), .CHG_GAP(CHG_GAP), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .c5(c5), .c10(c10), .c20(c20), .cancel_n(cancel_n),
    .disp_ack(disp_ack), .disp_req(disp_req), .chg5_pulse(chg5_pulse),
    .coin_rej(coin_rej), .vend_err(vend_err), .busy(busy), .led(led)
`ifdef SALES_AUDIT_EN
    , .sales_cnt(sales_cnt), .refund_cnt(refund_cnt)
`endif
  );

  vend_sequencer #(.PRICE_UNITS(15), .MAX_UNITS(15), .CHG_GAP(CHG_GAP), .ACK_TIMEOUT(255)) u_hi (
    .clk(clk), .rst(rst), .c5(c5), .c10(c10), .c20(c20), .cancel_n(cancel_n),
    .disp_ack(disp_ack), .disp_req(disp_req_h), .chg5_pulse(chg5_pulse_h),
    .coin_rej(coin_rej_h), .vend_err(vend_err_h), .busy(busy_h), .led(led_h)
`ifdef SALES_AUDIT_EN
    , .sales_cnt(sales_cnt_h), .refund_cnt(refund_cnt_h)
`endif
  );

  typedef struct {
    logic       c5, c10, c20, can, ack;
    logic [3:0] led;
    logic       rej, req, busy, chg;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v);
    case (k)
      0: c5 = v;
      1: c10 = v;
      2: c20 = v;
      default: cancel_n = v;
    endcase
  endtask

  // Press for one cycle then release; credit reflects the press on return.
  task automatic press(input int k);
    drive(k, 1'b0);
    tick;
    drive(k, 1'b1);
    tick;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b0;
    c5 = 1'b1; c10 = 1'b1; c20 = 1'b1; cancel_n = 1'b1; disp_ack = 1'b0;
    tick;
    tick;
    @(negedge clk);
    rst = 1'b1;
    tick;
  endtask

  // Runs a CHANGE/REFUND payout from its entry edge, modelling credit and
  // pulse spacing; optionally presses c5 at cycle rej_at to check rejection.
  task automatic run_out(input string nm, input int n_exp, input int credit0,
                         input int budget, input int rej_at);
    int n = 0, first = 0, last = 0, gap_err = 0, rej_cnt = 0;
    logic [3:0] exp_led;
    for (int c = 1; c <= budget; c++) begin
      if (rej_at > 0 && c == rej_at) c5 = 1'b0;
      if (rej_at > 0 && c == rej_at + 1) c5 = 1'b1;
      tick;
      if (chg5_pulse) begin
        n++;
        if (n == 1) first = c;
        else if (c - last != CHG_GAP) gap_err++;
        last = c;
      end
      if (coin_rej) rej_cnt++;
      exp_led = ~4'(credit0 - n);
      if (rej_at > 0) chk($sformatf("%s_led_c%0d", nm, c), 16'(led), 16'(exp_led));
      if (!busy) break;
    end
    chk({nm, "_pulses"}, 16'(n), 16'(n_exp));
    chk({nm, "_first"}, 16'(first), 16'(CHG_GAP));
    chk({nm, "_gaps"}, 16'(gap_err), 16'd0);
    chk({nm, "_led_end"}, 16'(led), 16'hF);
    chk({nm, "_idle"}, 16'(busy), 16'd0);
    if (rej_at > 0) chk({nm, "_rej"}, 16'(rej_cnt), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          c5    c10   c20   can   ack   led     rej   req   busy  chg
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF,  1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values, sampled while reset is held.
    #12;
    chk("rst_led", 16'(led), 16'hF);
    chk("rst_req", 16'(disp_req), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pulses", 16'({chg5_pulse, coin_rej, vend_err}), 16'd0);
    reset_dut;

    // Basic buy: c20, c20, c5 then ack in the third VEND cycle.
    for (int i = 0; i < 11; i++) begin
      c5 = tbl[i].c5; c10 = tbl[i].c10; c20 = tbl[i].c20;
      cancel_n = tbl[i].can; disp_ack = tbl[i].ack;
      tick;
      chk($sformatf("v%0d_led", i), 16'(led), 16'(tbl[i].led));
      chk($sformatf("v%0d_rej", i), 16'(coin_rej), 16'(tbl[i].rej));
      chk($sformatf("v%0d_req", i), 16'(disp_req), 16'(tbl[i].req));
      chk($sformatf("v%0d_busy", i), 16'(busy), 16'(tbl[i].busy));
      chk($sformatf("v%0d_chg", i), 16'(chg5_pulse), 16'(tbl[i].chg));
    end
    disp_ack = 1'b0;

    // Simultaneous c5 and c10: only c5 credited, coin_rej pulses once.
    c5 = 1'b0; c10 = 1'b0;
    tick;
    c5 = 1'b1; c10 = 1'b1;
    tick;
    chk("prio_led", 16'(led), 16'hE);
    chk("prio_rej", 16'(coin_rej), 16'd1);
    tick;
    chk("prio_rej_end", 16'(coin_rej), 16'd0);
    press(3);
    chk("prio_cancel_busy", 16'(busy), 16'd1);
    run_out("prio_ref", 1, 1, 20, 0);

    // 12 units then ack: 3 units of change.
    press(2); press(2); press(2);
    chk("chg_req", 16'(disp_req), 16'd1);
    chk("chg_led12", 16'(led), 16'h3);
    disp_ack = 1'b1;
    tick;
    disp_ack = 1'b0;
    chk("chg_req_drop", 16'(disp_req), 16'd0);
    chk("chg_led3", 16'(led), 16'hC);
    run_out("chg", 3, 3, 60, 0);

    // 6 units then cancel; a c5 during REFUND is rejected.
    press(2); press(1);
    chk("ref_led6", 16'(led), 16'h9);
    press(3);
    chk("ref_busy", 16'(busy), 16'd1);
    run_out("ref", 6, 6, 80, 5);

    // No ack: VEND lasts 255 cycles, then vend_err and a full refund.
    press(2); press(2);
    c5 = 1'b0;
    tick;
    c5 = 1'b1;
    tick;
    n = disp_req ? 1 : 0;
    for (int c = 0; c < 400; c++) begin
      tick;
      if (!disp_req) break;
      n++;
    end
    chk("tmo_cycles", 16'(n), 16'd255);
    chk("tmo_req", 16'(disp_req), 16'd0);
    chk("tmo_err", 16'(vend_err), 16'd1);
    chk("tmo_led9", 16'(led), 16'h6);
    run_out("tmo", 9, 9, 100, 0);

    // Reset asserted mid-VEND acts without a clock edge.
    press(2); press(2); press(0);
    chk("arst_req_before", 16'(disp_req), 16'd1);
    tick;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 16'(disp_req), 16'd0);
    chk("arst_led", 16'(led), 16'hF);
    chk("arst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    press(0);
    chk("arst_new_c5", 16'(led), 16'hE);
    chk("arst_new_busy", 16'(busy), 16'd0);

    // Overflow on the price-15 instance: 13 + 4 is rejected, 13 + 2 vends.
    reset_dut;
    press(2); press(2); press(2); press(0);
    chk("ovf_led13", 16'(led_h), 16'h2);
    press(2);
    chk("ovf_rej", 16'(coin_rej_h), 16'd1);
    chk("ovf_led_hold", 16'(led_h), 16'h2);
    press(1);
    chk("ovf_led15", 16'(led_h), 16'h0);
    chk("ovf_vend", 16'(disp_req_h), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
